// File: rtl/sfp_csr_pkg.sv
// Shared definitions for the multi-channel SFP CSR block.
// Register offsets, status word layout and event bit indices.
package sfp_csr_pkg;

  localparam int CH_STRIDE = 'h40;
  localparam int NUM_EV    = 7;
  localparam int CFG_A0_RST_BIT = 5;

  localparam logic [63:0] VERSION = 64'h0000_0000_0003_0000;

  localparam logic [5:0] OFF_VERSION = 6'h00;
  localparam logic [5:0] OFF_SCRATCH = 6'h08;
  localparam logic [5:0] OFF_INIT    = 6'h10;
  localparam logic [5:0] OFF_PEND    = 6'h18;

  localparam logic [5:0] OFF_CFG    = 6'h00;
  localparam logic [5:0] OFF_STAT   = 6'h08;
  localparam logic [5:0] OFF_STICKY = 6'h10;
  localparam logic [5:0] OFF_MASK   = 6'h18;
  localparam logic [5:0] OFF_DELAY  = 6'h20;

  // mod_det is bit 0, src_rdy bit 12
  typedef struct packed {
    logic [2:0] pad;
    logic       src_rdy;
    logic       snk_rdy;
    logic       a2_err;
    logic       a0_err;
    logic       a2_done;
    logic       a2_busy;
    logic       a0_done;
    logic       a0_busy;
    logic       a0_rdy;
    logic       rxlos;
    logic       txfault;
    logic       int_i2c;
    logic       mod_det;
  } ch_status_t;

  typedef enum logic [2:0] {
    EV_MOD_DET = 3'd0,
    EV_TXFAULT = 3'd1,
    EV_RXLOS   = 3'd2,
    EV_A0_DONE = 3'd3,
    EV_A2_DONE = 3'd4,
    EV_A0_ERR  = 3'd5,
    EV_A2_ERR  = 3'd6
  } ev_idx_e;

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/sfp_csr_chan.sv
// One SFP channel register bank: config, mask, delay and sticky events.
// Edge detection on live status feeds the W1C sticky bits.
module sfp_csr_chan
  import sfp_csr_pkg::*;
#(
  parameter logic [31:0] DELAY_RST = 32'h0BFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_cfg_i,
  input  logic              wr_stk_i,
  input  logic              wr_msk_i,
  input  logic              wr_dly_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        be_i,
  input  logic [NUM_EV-1:0] ev_i,
  input  logic              rst_a0_cfg_i,
  output logic [7:0]        cfg_o,
  output logic [6:0]        msk_o,
  output logic [6:0]        stk_o,
  output logic [31:0]       dly_o,
  output logic              pend_o
);

  logic [7:0]        cfg_q, cfg_d;
  logic [6:0]        msk_q, msk_d;
  logic [6:0]        stk_q, stk_d;
  logic [31:0]       dly_q, dly_d;
  logic [NUM_EV-1:0] ev_q;
  logic              rst_q;
  logic [31:0]       m;
  logic [NUM_EV-1:0] ev_set;

  always_comb begin
    m = '0;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be_i[i]}};
  end

  // mod_det reports both insertion and removal
  assign ev_set = {ev_i[NUM_EV-1:1] & ~ev_q[NUM_EV-1:1],
                   ev_i[0] ^ ev_q[0]};

  always_comb begin
    cfg_d = cfg_q;
    msk_d = msk_q;
    dly_d = dly_q;
    stk_d = stk_q;
    if (wr_cfg_i)
      cfg_d = (cfg_q & ~m[7:0]) | (wdata_i[7:0] & m[7:0]);
    if (rst_a0_cfg_i && !rst_q)
      cfg_d[CFG_A0_RST_BIT] = 1'b0;
    if (wr_msk_i)
      msk_d = (msk_q & ~m[6:0]) | (wdata_i[6:0] & m[6:0]);
    if (wr_dly_i)
      dly_d = (dly_q & ~m) | (wdata_i & m);
    if (wr_stk_i)
      stk_d = stk_q & ~(wdata_i[6:0] & m[6:0]);
    stk_d = stk_d | ev_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q <= '0;
      msk_q <= '0;
      stk_q <= '0;
      dly_q <= DELAY_RST;
      ev_q  <= '0;
      rst_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      msk_q <= msk_d;
      stk_q <= stk_d;
      dly_q <= dly_d;
      ev_q  <= ev_i;
      rst_q <= rst_a0_cfg_i;
    end
  end

  assign cfg_o  = cfg_q;
  assign msk_o  = msk_q;
  assign stk_o  = stk_q;
  assign dly_o  = dly_q;
  assign pend_o = |(stk_q & msk_q);

endmodule

// File: rtl/sfp_com_mc_csr.sv
// Multi-channel SFP CSR block: global regs, per-channel banks,
// address decode, registered read path and aggregated interrupt.
module sfp_com_mc_csr
  import sfp_csr_pkg::*;
#(
  parameter int          NUM_CH             = 4,
  parameter int          ADDR_WIDTH         = 10,
  parameter int          DATA_WIDTH         = 64,
  parameter int          ADDR_WIDTH_SFP_REG = 8,
  parameter logic [31:0] DELAY_RST          = 32'h0BFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic                   read,
  input  logic                   write,
  input  logic [DATA_WIDTH-1:0]  writedata,
  input  logic [7:0]             byteenable,
  output logic [DATA_WIDTH-1:0]  readdata,
  output logic                   readdatavalid,
  input  logic                   init_done,
  input  logic [NUM_CH*16-1:0]   ch_status_i,
  input  logic [NUM_CH-1:0]      ch_rst_a0_cfg_i,
  input  logic [NUM_CH*ADDR_WIDTH_SFP_REG-1:0] ch_curr_rd_addr_i,
  input  logic [NUM_CH*8-1:0]    ch_curr_rd_page_i,
  input  logic [NUM_CH*4-1:0]    ch_curr_fsm_i,
  output logic [NUM_CH*8-1:0]    ch_config_o,
  output logic [NUM_CH*32-1:0]   ch_delay_o,
  output logic                   irq
);

  localparam int BW  = ADDR_WIDTH - 6;
  localparam int ASR = ADDR_WIDTH_SFP_REG;

  logic [BW-1:0] blk;
  logic [5:0]    off;
  logic          glb;

  assign blk = address[ADDR_WIDTH-1:6];
  assign off = address[5:0];
  assign glb = (blk == '0);

  logic [7:0]  cfg   [NUM_CH];
  logic [6:0]  msk   [NUM_CH];
  logic [6:0]  stk   [NUM_CH];
  logic [31:0] dly   [NUM_CH];
  logic [63:0] stat_w[NUM_CH];
  logic [NUM_CH-1:0] pend;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic              hit;
    ch_status_t        st;
    logic [NUM_EV-1:0] ev;

    assign hit = write && (blk == BW'(g + 1));
    assign st  = ch_status_i[g*16 +: 16];

    always_comb begin
      ev = '0;
      ev[EV_MOD_DET] = st.mod_det;
      ev[EV_TXFAULT] = st.txfault;
      ev[EV_RXLOS]   = st.rxlos;
      ev[EV_A0_DONE] = st.a0_done;
      ev[EV_A2_DONE] = st.a2_done;
      ev[EV_A0_ERR]  = st.a0_err;
      ev[EV_A2_ERR]  = st.a2_err;
    end

    sfp_csr_chan #(
      .DELAY_RST (DELAY_RST)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .wr_cfg_i     (hit && (off == OFF_CFG)),
      .wr_stk_i     (hit && (off == OFF_STICKY)),
      .wr_msk_i     (hit && (off == OFF_MASK)),
      .wr_dly_i     (hit && (off == OFF_DELAY)),
      .wdata_i      (writedata[31:0]),
      .be_i         (byteenable[3:0]),
      .ev_i         (ev),
      .rst_a0_cfg_i (ch_rst_a0_cfg_i[g]),
      .cfg_o        (cfg[g]),
      .msk_o        (msk[g]),
      .stk_o        (stk[g]),
      .dly_o        (dly[g]),
      .pend_o       (pend[g])
    );

    assign stat_w[g] = 64'({ch_curr_fsm_i[g*4 +: 4],
                            ch_curr_rd_page_i[g*8 +: 8],
                            ch_curr_rd_addr_i[g*ASR +: ASR],
                            st});

    assign ch_config_o[g*8 +: 8]  = cfg[g];
    assign ch_delay_o[g*32 +: 32] = dly[g];
  end

  logic [63:0] scratch_q, scratch_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rvalid_q;
  logic        irq_q;
  logic [63:0] bm;

  assign bm = be_mask(byteenable);

  always_comb begin
    scratch_d = scratch_q;
    if (write && glb && (off == OFF_SCRATCH))
      scratch_d = (scratch_q & ~bm) | (64'(writedata) & bm);
  end

  // Decode uses current register contents, so a same-cycle write is not seen
  always_comb begin
    rdata_d = '0;
    if (glb) begin
      case (off)
        OFF_VERSION: rdata_d = VERSION;
        OFF_SCRATCH: rdata_d = scratch_q;
        OFF_INIT:    rdata_d = 64'(init_done);
        OFF_PEND:    rdata_d = 64'(pend);
        default:     rdata_d = '0;
      endcase
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (blk == BW'(i + 1)) begin
        case (off)
          OFF_CFG:    rdata_d = 64'(cfg[i]);
          OFF_STAT:   rdata_d = stat_w[i];
          OFF_STICKY: rdata_d = 64'(stk[i]);
          OFF_MASK:   rdata_d = 64'(msk[i]);
          OFF_DELAY:  rdata_d = 64'(dly[i]);
          default:    rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      rvalid_q  <= read;
      irq_q     <= |pend;
      if (read) rdata_q <= rdata_d;
    end
  end

  assign readdata      = DATA_WIDTH'(rdata_q);
  assign readdatavalid = rvalid_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_sfp_com_mc_csr.sv
// Directed self-checking bench for sfp_com_mc_csr (NUM_CH = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sfp_com_mc_csr;

  localparam int NCH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    address;
  logic          read;
  logic          write;
  logic [63:0]   writedata;
  logic [7:0]    byteenable;
  logic [63:0]   readdata;
  logic          readdatavalid;
  logic          init_done;
  logic [NCH*16-1:0] ch_status;
  logic [NCH-1:0]    ch_rst_a0_cfg;
  logic [NCH*8-1:0]  ch_curr_rd_addr;
  logic [NCH*8-1:0]  ch_curr_rd_page;
  logic [NCH*4-1:0]  ch_curr_fsm;
  logic [NCH*8-1:0]  ch_config;
  logic [NCH*32-1:0] ch_delay;
  logic          irq;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sfp_com_mc_csr #(.NUM_CH(NCH)) dut (
    .clk               (clk),
    .reset             (reset),
    .address           (address),
    .read              (read),
    .write             (write),
    .writedata         (writedata),
    .byteenable        (byteenable),
    .readdata          (readdata),
    .readdatavalid     (readdatavalid),
    .init_done         (init_done),
    .ch_status_i       (ch_status),
    .ch_rst_a0_cfg_i   (ch_rst_a0_cfg),
    .ch_curr_rd_addr_i (ch_curr_rd_addr),
    .ch_curr_rd_page_i (ch_curr_rd_page),
    .ch_curr_fsm_i     (ch_curr_fsm),
    .ch_config_o       (ch_config),
    .ch_delay_o        (ch_delay),
    .irq               (irq)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Caller is at a falling edge; returns at the next falling edge.
  task automatic wr(input logic [9:0] a, input logic [63:0] d,
                    input logic [7:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [9:0] a,
                    input logic [63:0] exp);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    chk({tag, "_vld"}, 64'(readdatavalid), 64'd1);
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; byteenable = '0; init_done = 1'b0;
    ch_status = '0; ch_rst_a0_cfg = '0;
    ch_curr_rd_addr = '0; ch_curr_rd_page = '0; ch_curr_fsm = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdv", 64'(readdatavalid), 64'd0);
    chk("rst_rdata", readdata, 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    rd("ch0_delay", 10'h060, 64'h0BFF);
    rd("ch0_cfg", 10'h040, 64'h0);
    rd("version", 10'h000, 64'h0000_0000_0003_0000);
    rd("scratch0", 10'h008, 64'h0);
    chk("dly_port", 64'(ch_delay[31:0]), 64'h0BFF);

    wr(10'h008, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    rd("scratch_be0f", 10'h008, 64'h0000_0000_CCCC_DDDD);
    wr(10'h008, 64'h1111_2222_3333_4444, 8'hF0);
    rd("scratch_bef0", 10'h008, 64'h1111_2222_CCCC_DDDD);

    init_done = 1'b1;
    rd("init_done", 10'h010, 64'h1);

    // rxlos rises in the same cycle the mask is written
    ch_status[3] = 1'b1;
    wr(10'h058, 64'h04, 8'hFF);
    chk("irq_lat", 64'(irq), 64'd0);
    @(negedge clk);
    chk("irq_set", 64'(irq), 64'd1);
    rd("sticky_rx", 10'h050, 64'h04);
    rd("pend", 10'h018, 64'h1);
    wr(10'h050, 64'h04, 8'hFF);
    chk("irq_hold", 64'(irq), 64'd1);
    @(negedge clk);
    chk("irq_clr", 64'(irq), 64'd0);
    rd("sticky_clr", 10'h050, 64'h0);

    ch_status[2] = 1'b1;
    @(negedge clk);
    rd("sticky_tx", 10'h050, 64'h02);
    ch_status[2] = 1'b0;
    @(negedge clk);
    ch_status[2] = 1'b1;
    wr(10'h050, 64'h02, 8'hFF);
    rd("w1c_vs_set", 10'h050, 64'h02);
    wr(10'h050, 64'h02, 8'hFF);
    rd("w1c_tx", 10'h050, 64'h0);

    ch_status[0] = 1'b1;
    @(negedge clk);
    rd("moddet_rise", 10'h050, 64'h01);
    wr(10'h050, 64'h01, 8'hFF);
    ch_status[0] = 1'b0;
    @(negedge clk);
    rd("moddet_fall", 10'h050, 64'h01);
    chk("irq_masked", 64'(irq), 64'd0);

    wr(10'h080, 64'h20, 8'hFF);
    rd("ch1_cfg", 10'h080, 64'h20);
    ch_rst_a0_cfg[1] = 1'b1;
    wr(10'h080, 64'hFF, 8'hFF);
    rd("ch1_cfg_rst", 10'h080, 64'hDF);
    chk("ch1_cfg_port", 64'(ch_config[15:8]), 64'hDF);
    wr(10'h080, 64'hFF, 8'hFF);
    rd("ch1_cfg_lvl", 10'h080, 64'hFF);
    ch_rst_a0_cfg[1] = 1'b0;

    wr(10'h0E0, 64'h55, 8'h01);
    rd("ch2_dly_be", 10'h0E0, 64'h0B55);
    chk("ch2_dly_port", 64'(ch_delay[95:64]), 64'h0B55);

    ch_status[63:48] = 16'hA5A5;
    ch_curr_rd_addr[31:24] = 8'h12;
    ch_curr_rd_page[31:24] = 8'h34;
    ch_curr_fsm[15:12] = 4'h5;
    rd("ch3_stat", 10'h108, 64'h0000_0005_3412_A5A5);

    wr(10'h3F8, 64'hFFFF, 8'hFF);
    rd("unmapped", 10'h3F8, 64'h0);
    rd("ch4_unmapped", 10'h140, 64'h0);

    // back-to-back reads
    address = 10'h000; read = 1'b1;
    @(negedge clk);
    chk("b2b0_vld", 64'(readdatavalid), 64'd1);
    chk("b2b0", readdata, 64'h0000_0000_0003_0000);
    address = 10'h3F8;
    @(negedge clk);
    chk("b2b1_vld", 64'(readdatavalid), 64'd1);
    chk("b2b1", readdata, 64'h0);
    address = 10'h060;
    @(negedge clk);
    read = 1'b0;
    chk("b2b2_vld", 64'(readdatavalid), 64'd1);
    chk("b2b2", readdata, 64'h0BFF);
    @(negedge clk);
    chk("idle_vld", 64'(readdatavalid), 64'd0);

    // read and write together: read sees the old value
    address = 10'h008; writedata = 64'h0123_4567_89AB_CDEF;
    byteenable = 8'hFF; read = 1'b1; write = 1'b1;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    chk("rw_old", readdata, 64'h1111_2222_CCCC_DDDD);
    rd("rw_new", 10'h008, 64'h0123_4567_89AB_CDEF);

    // reset while a read is outstanding
    address = 10'h060; read = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk);
    read = 1'b0;
    chk("rst_mid_vld", 64'(readdatavalid), 64'd0);
    reset = 1'b0;
    chk("rst2_irq", 64'(irq), 64'd0);
    rd("rst2_cfg1", 10'h080, 64'h0);
    rd("rst2_scr", 10'h008, 64'h0);
    rd("rst2_dly2", 10'h0E0, 64'h0BFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
